// File: rtl/imp_queue.sv
// Implication queue: dedups implied literals against an assignment table, flags conflicts, buffers new literals in a FIFO.
// Latency: a literal pushed at edge N is presented on out_* after edge N; head is shown combinationally.
// Backpressure: imp_ready drops when the FIFO is full, in conflict, or clearing; out_* holds while out_ready is low.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   initial_sign        - synchronous clear while clause initialisation runs
//   imp_valid/imp_var/imp_val/imp_ready - implied literal input handshake
//   out_valid/out_var/out_val/out_ready - propagation-side handshake (FIFO head)
//   conflict, conflict_var              - sticky conflict flag and offending variable
//   count                               - FIFO occupancy
//   assign_mask, assign_val             - per-variable assigned flag and value
module imp_queue #(
  parameter int VAR_W = 3,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     initial_sign,
  input  logic                     imp_valid,
  input  logic [VAR_W-1:0]         imp_var,
  input  logic                     imp_val,
  output logic                     imp_ready,
  output logic                     out_valid,
  output logic [VAR_W-1:0]         out_var,
  output logic                     out_val,
  input  logic                     out_ready,
  output logic                     conflict,
  output logic [VAR_W-1:0]         conflict_var,
  output logic [$clog2(DEPTH):0]   count,
  output logic [2**VAR_W-1:0]      assign_mask,
  output logic [2**VAR_W-1:0]      assign_val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Each FIFO entry is {variable, value}.
  logic [VAR_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic full;
  logic push;
  logic pop;
  logic hit;
  logic same;
  logic enq;
  logic clash;
  logic clear;

  always_comb begin
    full      = (count == FULL_CNT);
    clear     = rst || initial_sign;
    // Deliberately ignores a same-cycle pop: a full queue never accepts.
    imp_ready = !full && !conflict && !initial_sign && !rst;
    push      = imp_valid && imp_ready;

    // Classification uses the table as it stands before the edge.
    hit   = assign_mask[imp_var];
    same  = (assign_val[imp_var] == imp_val);
    enq   = push && !hit;
    clash = push && hit && !same;

    out_valid = (count != '0) && !conflict;
    pop       = out_valid && out_ready;

    {out_var, out_val} = mem[rd_ptr];
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= {imp_var, imp_val};
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      assign_mask  <= '0;
      assign_val   <= '0;
      conflict     <= 1'b0;
      conflict_var <= '0;
    end else if (clash) begin
      // Flush the queue but keep the assignment table for debug.
      conflict     <= 1'b1;
      conflict_var <= imp_var;
      count        <= '0;
      rd_ptr       <= wr_ptr;
    end else begin
      if (enq) begin
        assign_mask[imp_var] <= 1'b1;
        assign_val[imp_var]  <= imp_val;
        wr_ptr               <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imp_queue.sv
module tb_imp_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       initial_sign = 1'b0;
  logic       imp_valid = 1'b0;
  logic [2:0] imp_var = 3'd0;
  logic       imp_val = 1'b0;
  logic       imp_ready;
  logic       out_valid;
  logic [2:0] out_var;
  logic       out_val;
  logic       out_ready = 1'b0;
  logic       conflict;
  logic [2:0] conflict_var;
  logic [3:0] count;
  logic [7:0] assign_mask;
  logic [7:0] assign_val;

  int total = 0;
  int bad   = 0;

  imp_queue #(.VAR_W(3), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .initial_sign (initial_sign),
    .imp_valid    (imp_valid),
    .imp_var      (imp_var),
    .imp_val      (imp_val),
    .imp_ready    (imp_ready),
    .out_valid    (out_valid),
    .out_var      (out_var),
    .out_val      (out_val),
    .out_ready    (out_ready),
    .conflict     (conflict),
    .conflict_var (conflict_var),
    .count        (count),
    .assign_mask  (assign_mask),
    .assign_val   (assign_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; initial_sign = 1'b0; imp_valid = 1'b0; out_ready = 1'b0;
  endtask

  // One clock with the given inputs, then inputs go idle so state-only outputs can be checked.
  task automatic cyc(input logic r, input logic ini, input logic iv, input logic [2:0] v,
                     input logic vl, input logic ordy);
    rst = r; initial_sign = ini; imp_valid = iv; imp_var = v; imp_val = vl; out_ready = ordy;
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  typedef struct packed {
    logic       r;
    logic       ini;
    logic       iv;
    logic [2:0] v;
    logic       vl;
    logic       ordy;
    logic [3:0] e_cnt;
    logic       e_ov;
    logic [2:0] e_hvar;
    logic       e_hval;
    logic [7:0] e_mask;
    logic [7:0] e_aval;
    logic       e_conf;
    logic [2:0] e_cvar;
    logic       e_ir;
  } vec_t;

  vec_t vec [11];

  // Reference model: queue of literals plus the assignment table.
  logic [3:0] mq [$];
  logic [7:0] m_mask;
  logic [7:0] m_aval;
  logic       m_conf;
  logic [2:0] m_cvar;

  initial begin
    //            r  i  iv v    vl or  cnt ov hv   hl mask   aval   cf cv   ir
    vec[0]  = '{1'b1,1'b0,1'b0,3'd0,1'b0,1'b0, 4'd0,1'b0,3'd0,1'b0,8'h00,8'h00,1'b0,3'd0,1'b1};
    vec[1]  = '{1'b0,1'b0,1'b1,3'd2,1'b1,1'b0, 4'd1,1'b1,3'd2,1'b1,8'h04,8'h04,1'b0,3'd0,1'b1};
    vec[2]  = '{1'b0,1'b0,1'b1,3'd5,1'b0,1'b0, 4'd2,1'b1,3'd2,1'b1,8'h24,8'h04,1'b0,3'd0,1'b1};
    vec[3]  = '{1'b0,1'b0,1'b1,3'd2,1'b1,1'b0, 4'd2,1'b1,3'd2,1'b1,8'h24,8'h04,1'b0,3'd0,1'b1};
    vec[4]  = '{1'b0,1'b0,1'b0,3'd0,1'b0,1'b1, 4'd1,1'b1,3'd5,1'b0,8'h24,8'h04,1'b0,3'd0,1'b1};
    vec[5]  = '{1'b0,1'b0,1'b0,3'd0,1'b0,1'b1, 4'd0,1'b0,3'd0,1'b0,8'h24,8'h04,1'b0,3'd0,1'b1};
    vec[6]  = '{1'b0,1'b0,1'b1,3'd3,1'b1,1'b0, 4'd1,1'b1,3'd3,1'b1,8'h2C,8'h0C,1'b0,3'd0,1'b1};
    vec[7]  = '{1'b0,1'b0,1'b1,3'd3,1'b0,1'b0, 4'd0,1'b0,3'd0,1'b0,8'h2C,8'h0C,1'b1,3'd3,1'b0};
    vec[8]  = '{1'b0,1'b1,1'b0,3'd0,1'b0,1'b0, 4'd0,1'b0,3'd0,1'b0,8'h00,8'h00,1'b0,3'd0,1'b1};
    vec[9]  = '{1'b0,1'b1,1'b1,3'd1,1'b1,1'b0, 4'd0,1'b0,3'd0,1'b0,8'h00,8'h00,1'b0,3'd0,1'b1};
    vec[10] = '{1'b1,1'b0,1'b1,3'd6,1'b1,1'b1, 4'd0,1'b0,3'd0,1'b0,8'h00,8'h00,1'b0,3'd0,1'b1};

    idle();
    @(posedge clk);
    #1;

    // Table-driven directed vectors
    for (int i = 0; i < 11; i++) begin
      cyc(vec[i].r, vec[i].ini, vec[i].iv, vec[i].v, vec[i].vl, vec[i].ordy);
      chk($sformatf("v%0d_count", i), count, vec[i].e_cnt);
      chk($sformatf("v%0d_out_valid", i), out_valid, vec[i].e_ov);
      if (vec[i].e_ov) begin
        chk($sformatf("v%0d_head", i), {out_var, out_val}, {vec[i].e_hvar, vec[i].e_hval});
      end
      chk($sformatf("v%0d_mask", i), assign_mask, vec[i].e_mask);
      chk($sformatf("v%0d_aval", i), assign_val, vec[i].e_aval);
      chk($sformatf("v%0d_conflict", i), conflict, vec[i].e_conf);
      chk($sformatf("v%0d_conflict_var", i), conflict_var, vec[i].e_cvar);
      chk($sformatf("v%0d_imp_ready", i), imp_ready, vec[i].e_ir);
    end

    // Full and wrap
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v3;
      v3 = 3'(i);
      cyc(0, 0, 1, v3, v3[0], 0);
    end
    chk("full_count", count, 4'd8);
    chk("full_imp_ready", imp_ready, 1'b0);
    imp_valid = 1'b1; imp_var = 3'd0; out_ready = 1'b1;
    #1;
    chk("full_ready_with_pop", imp_ready, 1'b0);
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] k3;
      k3 = 3'(k);
      chk($sformatf("wrap_head%0d", k), {out_var, out_val}, {k3, k3[0]});
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("wrap_count_after_pop3", count, 4'd5);
    cyc(0, 0, 1, 3'd0, 1'b0, 0);
    chk("wrap_dup_discard", count, 4'd5);
    for (int k = 3; k < 8; k++) begin
      logic [2:0] k3;
      k3 = 3'(k);
      chk($sformatf("wrap_head%0d", k), {out_var, out_val}, {k3, k3[0]});
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("drain_out_valid", out_valid, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("underflow_count", count, 4'd0);

    // Simultaneous push and pop at count 4
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 3'(i), 1'b1, 0);
    chk("pp_count_before", count, 4'd4);
    chk("pp_head_before", out_var, 3'd1);
    cyc(0, 0, 1, 3'd5, 1'b1, 1);
    chk("pp_count_after", count, 4'd4);
    chk("pp_head_after", out_var, 3'd2);

    // Reset with six queued
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 3'(i), 1'b0, 0);
    chk("rst6_count_before", count, 4'd6);
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst6_count_after", count, 4'd0);
    chk("rst6_out_valid", out_valid, 1'b0);
    chk("rst6_mask", assign_mask, 8'h00);

    // Randomized run against the reference model
    cyc(1, 0, 0, 0, 0, 0);
    mq.delete(); m_mask = '0; m_aval = '0; m_conf = 1'b0; m_cvar = '0;
    for (int n = 0; n < 3000; n++) begin
      logic       e_ir, e_ov, do_push, do_pop;
      logic [2:0] rv;
      rst          = ($urandom_range(0, 149) == 0);
      initial_sign = ($urandom_range(0, 24) == 0);
      imp_valid    = ($urandom_range(0, 9) < 6);
      rv           = 3'($urandom_range(0, 7));
      imp_var      = rv;
      imp_val      = m_mask[rv] ? (($urandom_range(0, 99) < 85) ? m_aval[rv] : ~m_aval[rv])
                                : 1'($urandom_range(0, 1));
      out_ready    = ($urandom_range(0, 1) == 1);
      #1;
      e_ir = (mq.size() < 8) && !m_conf && !initial_sign && !rst;
      e_ov = (mq.size() != 0) && !m_conf;
      chk("rnd_imp_ready", imp_ready, e_ir);
      chk("rnd_out_valid", out_valid, e_ov);
      if (e_ov) chk("rnd_head", {out_var, out_val}, mq[0]);
      chk("rnd_count", count, 32'(mq.size()));
      chk("rnd_conflict", conflict, m_conf);
      chk("rnd_conflict_var", conflict_var, m_cvar);
      chk("rnd_mask", assign_mask, m_mask);
      chk("rnd_aval", assign_val, m_aval);

      do_push = imp_valid && e_ir;
      do_pop  = e_ov && out_ready;
      if (rst || initial_sign) begin
        mq.delete(); m_mask = '0; m_aval = '0; m_conf = 1'b0; m_cvar = '0;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          if (!m_mask[rv]) begin
            m_mask[rv] = 1'b1;
            m_aval[rv] = imp_val;
            mq.push_back({rv, imp_val});
          end else if (m_aval[rv] != imp_val) begin
            m_conf = 1'b1;
            m_cvar = rv;
            mq.delete();
          end
        end
      end
      @(posedge clk);
      #1;
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
